// File: rtl/sfq_gate_tree_pkg.sv
// sfq_gate_tree_pkg: shared cell function enum and tree-shape helpers for the SFQ gate tree.
package sfq_gate_tree_pkg;

  localparam int unsigned SFQ_MAX_N = 16;

  typedef enum logic [1:0] {
    GOP_AND = 2'd0,
    GOP_OR  = 2'd1,
    GOP_XOR = 2'd2
  } gate_op_e;

  // Result of one 2-input cell for the given function.
  function automatic logic sfq_eval(input gate_op_e op, input logic a, input logic b);
    logic r;
    r = 1'b0;
    case (op)
      GOP_AND: r = a & b;
      GOP_OR:  r = a | b;
      GOP_XOR: r = a ^ b;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Number of nodes produced after lvl pairing levels starting from n leaves.
  function automatic int unsigned node_count(input int unsigned n, input int unsigned lvl);
    int unsigned c;
    c = n;
    for (int unsigned i = 0; (i < lvl) && (i < SFQ_MAX_N); i++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

endpackage

// File: rtl/sfq_cell.sv
// sfq_cell: one clocked SFQ node, either a 2-input gate (N_IN=2) or a 1-input DRO buffer (N_IN=1).
module sfq_cell
  import sfq_gate_tree_pkg::*;
#(
  parameter int unsigned N_IN = 2,
  parameter gate_op_e    OP   = GOP_AND
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic [N_IN-1:0] pulse_in,
  output logic            pulse_out_c
);

  logic [N_IN-1:0] arrived_q;
  logic [N_IN-1:0] arrived_d;
  logic            eval_c;

  // Tick closes the window first; a same-cycle pulse then arms the next window.
  always_comb begin
    arrived_d = arrived_q;
    if (tick) begin
      arrived_d = '0;
    end
    arrived_d = arrived_d | pulse_in;
  end

  // Arrival flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arrived_q <= '0;
    end else begin
      arrived_q <= arrived_d;
    end
  end

  if (N_IN == 2) begin : g_gate
    assign eval_c = sfq_eval(OP, arrived_q[0], arrived_q[1]);
  end else begin : g_dro
    // Buffer re-emits its stored pulse: the gate fed with the op's identity element.
    assign eval_c = sfq_eval(OP, arrived_q[0], OP == GOP_AND);
  end

  assign pulse_out_c = tick & eval_c;

endmodule

// File: rtl/sfq_gate_tree.sv
// sfq_gate_tree: balanced tree of clocked SFQ cells over N_INPUTS pulse inputs.
// Optional macro SFQ_SETUP_CHECK_EN adds the sticky err_setup output.
module sfq_gate_tree
  import sfq_gate_tree_pkg::*;
#(
  parameter int unsigned N_INPUTS = 3,
  parameter int unsigned GATE_OP  = 0,
  parameter int unsigned LEVELS   = $clog2(N_INPUTS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_sent,
  input  logic [N_INPUTS-1:0] in_sent,
  output logic                out_data,
  output logic                out_sent
`ifdef SFQ_SETUP_CHECK_EN
  ,
  output logic                err_setup
`endif
);

  localparam gate_op_e OP = gate_op_e'(2'(GATE_OP));

  logic                clk_sent_q, clk_sent_d;
  logic [N_INPUTS-1:0] in_sent_q, in_sent_d;
  logic                armed_q, armed_d;
  logic                out_sent_q, out_sent_d;
  logic                out_data_q, out_data_d;
  logic                tick_c;
  logic [N_INPUTS-1:0] pulse_c;
  logic                root_c;

  // Edge detection; armed_q blanks the first cycle after reset so held-high levels give no edge.
  always_comb begin
    clk_sent_d = clk_sent;
    in_sent_d  = in_sent;
    armed_d    = 1'b1;
    tick_c     = armed_q & clk_sent & ~clk_sent_q;
    pulse_c    = {N_INPUTS{armed_q}} & in_sent & ~in_sent_q;
  end

  // One evaluation strobe per tick; data carries the root cell result.
  always_comb begin
    out_sent_d = tick_c;
    out_data_d = tick_c & root_c;
  end

  // Edge and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sent_q <= 1'b0;
      in_sent_q  <= '0;
      armed_q    <= 1'b0;
      out_sent_q <= 1'b0;
      out_data_q <= 1'b0;
    end else begin
      clk_sent_q <= clk_sent_d;
      in_sent_q  <= in_sent_d;
      armed_q    <= armed_d;
      out_sent_q <= out_sent_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_sent = out_sent_q;
  assign out_data = out_data_q;

  // Tree levels: pairs feed gates, an odd last node feeds a DRO buffer to keep depth balanced.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned CNT_IN  = node_count(N_INPUTS, l);
    localparam int unsigned CNT_OUT = node_count(N_INPUTS, l + 1);

    logic [CNT_IN-1:0]  lvl_in;
    logic [CNT_OUT-1:0] lvl_out;

    if (l == 0) begin : g_src
      assign lvl_in = pulse_c;
    end else begin : g_src
      assign lvl_in = g_lvl[l-1].lvl_out;
    end

    for (genvar j = 0; j < CNT_OUT; j++) begin : g_node
      if (2 * j + 1 < CNT_IN) begin : g_cell
        sfq_cell #(
          .N_IN (2),
          .OP   (OP)
        ) u_cell (
          .clk         (clk),
          .rst_n       (rst_n),
          .tick        (tick_c),
          .pulse_in    (lvl_in[2*j+1:2*j]),
          .pulse_out_c (lvl_out[j])
        );
      end else begin : g_buf
        sfq_cell #(
          .N_IN (1),
          .OP   (OP)
        ) u_buf (
          .clk         (clk),
          .rst_n       (rst_n),
          .tick        (tick_c),
          .pulse_in    (lvl_in[2*j]),
          .pulse_out_c (lvl_out[j])
        );
      end
    end
  end

  assign root_c = g_lvl[LEVELS-1].lvl_out[0];

`ifdef SFQ_SETUP_CHECK_EN
  logic err_setup_q, err_setup_d;

  // Sticky flag: a data pulse landing on the same cycle as a tick.
  always_comb begin
    err_setup_d = err_setup_q | (tick_c & (|pulse_c));
  end

  // Setup error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_setup_q <= 1'b0;
    end else begin
      err_setup_q <= err_setup_d;
    end
  end

  assign err_setup = err_setup_q;
`endif

endmodule

// File: tb/tb_sfq_gate_tree.sv
// tb_sfq_gate_tree: five tree configurations driven in parallel and checked every cycle
// against a window/delay-line model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_sfq_gate_tree;

  localparam int NDUT = 5;
  // Configurations: N_INPUTS, op (0 AND, 1 OR, 2 XOR), depth = clog2(N).
  localparam int NN  [NDUT] = '{3, 5, 4, 4, 2};
  localparam int OPS [NDUT] = '{0, 1, 2, 0, 2};
  localparam int LV  [NDUT] = '{2, 3, 2, 2, 1};

  logic            clk;
  logic            rst_n;
  logic            clk_sent;
  logic [15:0]     ins [NDUT];
  logic [NDUT-1:0] od, os, oe;

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sfq_gate_tree #(.N_INPUTS(3), .GATE_OP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clk_sent(clk_sent), .in_sent(ins[0][2:0]),
    .out_data(od[0]), .out_sent(os[0])
`ifdef SFQ_SETUP_CHECK_EN
    , .err_setup(oe[0])
`endif
  );
  sfq_gate_tree #(.N_INPUTS(5), .GATE_OP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clk_sent(clk_sent), .in_sent(ins[1][4:0]),
    .out_data(od[1]), .out_sent(os[1])
`ifdef SFQ_SETUP_CHECK_EN
    , .err_setup(oe[1])
`endif
  );
  sfq_gate_tree #(.N_INPUTS(4), .GATE_OP(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clk_sent(clk_sent), .in_sent(ins[2][3:0]),
    .out_data(od[2]), .out_sent(os[2])
`ifdef SFQ_SETUP_CHECK_EN
    , .err_setup(oe[2])
`endif
  );
  sfq_gate_tree #(.N_INPUTS(4), .GATE_OP(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clk_sent(clk_sent), .in_sent(ins[3][3:0]),
    .out_data(od[3]), .out_sent(os[3])
`ifdef SFQ_SETUP_CHECK_EN
    , .err_setup(oe[3])
`endif
  );
  sfq_gate_tree #(.N_INPUTS(2), .GATE_OP(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clk_sent(clk_sent), .in_sent(ins[4][1:0]),
    .out_data(od[4]), .out_sent(os[4])
`ifdef SFQ_SETUP_CHECK_EN
    , .err_setup(oe[4])
`endif
  );

`ifndef SFQ_SETUP_CHECK_EN
  assign oe = '0;
`endif

  // ---------------- reference model ----------------
  // A window collects every input that rose since the previous tick; at a tick the whole
  // window reduces under the op, and that result is reported LEVELS-1 ticks later.
  bit        m_armed;
  bit        m_prev_clk;
  bit [15:0] m_prev_in [NDUT];
  bit [15:0] m_win     [NDUT];
  bit [3:0]  m_pipe    [NDUT];   // bit k = window result reduced k ticks ago
  bit        exp_s [NDUT];
  bit        exp_d [NDUT];
  bit        exp_e [NDUT];

  function automatic bit reduce_win(int op, int n, bit [15:0] w);
    bit [15:0] full;
    full = 16'((32'd1 << n) - 1);
    case (op)
      0:       return (w & full) == full;
      1:       return |w;
      default: return ^w;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_armed    = 1'b0;
      m_prev_clk = 1'b0;
      for (int d = 0; d < NDUT; d++) begin
        m_prev_in[d] = '0;
        m_win[d]     = '0;
        m_pipe[d]    = '0;
        exp_s[d]     = 1'b0;
        exp_d[d]     = 1'b0;
        exp_e[d]     = 1'b0;
      end
    end else begin
      bit        tk;
      bit [15:0] pl;
      bit [15:0] msk;
      bit        r;
      tk = m_armed && clk_sent && !m_prev_clk;
      for (int d = 0; d < NDUT; d++) begin
        msk = 16'((32'd1 << NN[d]) - 1);
        pl  = m_armed ? (ins[d] & ~m_prev_in[d] & msk) : 16'd0;
        if (tk) begin
          r         = reduce_win(OPS[d], NN[d], m_win[d]);
          exp_d[d]  = (LV[d] == 1) ? r : m_pipe[d][LV[d]-2];
          m_pipe[d] = {m_pipe[d][2:0], r};
          m_win[d]  = pl;
          if (pl != 16'd0) exp_e[d] = 1'b1;
        end else begin
          exp_d[d] = 1'b0;
          m_win[d] = m_win[d] | pl;
        end
        exp_s[d]     = tk;
        m_prev_in[d] = ins[d] & msk;
      end
      m_prev_clk = clk_sent;
      m_armed    = 1'b1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int d, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %b expected %b", nm, d, $time, act, exp);
    end
  endtask

  // Advance one clock and compare every DUT against the model, 2ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
    for (int d = 0; d < NDUT; d++) begin
      chk("model_out_sent", d, os[d], exp_s[d]);
      chk("model_out_data", d, od[d], exp_d[d]);
`ifdef SFQ_SETUP_CHECK_EN
      chk("model_err_setup", d, oe[d], exp_e[d]);
`endif
    end
  endtask

  task automatic pulse(input int d, input logic [15:0] m);
    ins[d] = m;
    cyc();
    ins[d] = '0;
  endtask

  // Low cycle, then a rising clk_sent; returns just after the tick edge.
  task automatic do_tick();
    cyc();
    clk_sent = 1'b1;
    cyc();
    clk_sent = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    clk_sent = 1'b0;
    for (int d = 0; d < NDUT; d++) ins[d] = '0;
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_out_sent", d, os[d], 1'b0);
      chk("reset_out_data", d, od[d], 1'b0);
      chk("reset_err_setup", d, oe[d], 1'b0);
    end
    rst_n = 1'b1;
    cyc();

    // N=3 AND: full window -> result after second tick only.
    pulse(0, 16'h7);
    do_tick(); chk("n3_t1_sent", 0, os[0], 1'b1); chk("n3_t1_data", 0, od[0], 1'b0);
    do_tick(); chk("n3_t2_sent", 0, os[0], 1'b1); chk("n3_t2_data", 0, od[0], 1'b1);
    do_tick(); chk("n3_t3_data", 0, od[0], 1'b0);

    // N=3 AND: partial window gives 0, no carry-over into a later full window.
    pulse(0, 16'h3);
    do_tick(); chk("n3p_t1_data", 0, od[0], 1'b0);
    do_tick(); chk("n3p_t2_data", 0, od[0], 1'b0);
    pulse(0, 16'h7);
    do_tick(); chk("n3p_t3_data", 0, od[0], 1'b0);
    do_tick(); chk("n3p_t4_data", 0, od[0], 1'b1);

    // N=5 OR: lone pulse through the buffered path needs three ticks.
    pulse(1, 16'h10);
    do_tick(); chk("n5_t1_data", 1, od[1], 1'b0);
    do_tick(); chk("n5_t2_data", 1, od[1], 1'b0);
    do_tick(); chk("n5_t3_data", 1, od[1], 1'b1); chk("n5_t3_sent", 1, os[1], 1'b1);
    do_tick(); chk("n5_t4_data", 1, od[1], 1'b0);

    // N=4 XOR: pulses coincident with the tick fall into the next window.
    cyc();
    clk_sent = 1'b1;
    ins[2]   = 16'h7;
    cyc();
    clk_sent = 1'b0;
    ins[2]   = '0;
    chk("x4_t1_sent", 2, os[2], 1'b1);
    chk("x4_t1_data", 2, od[2], 1'b0);
`ifdef SFQ_SETUP_CHECK_EN
    chk("x4_err_set", 2, oe[2], 1'b1);
    chk("x4_err_other", 0, oe[0], 1'b0);
`endif
    do_tick(); chk("x4_t2_data", 2, od[2], 1'b0);
    do_tick(); chk("x4_t3_data", 2, od[2], 1'b1);

    // N=4 AND: reset right after a tick clears outputs at once and drops in-flight data.
    pulse(3, 16'hF);
    do_tick(); chk("rst_pre_sent", 3, os[3], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_now_sent", 3, os[3], 1'b0);
    chk("rst_now_data", 3, od[3], 1'b0);
    chk("rst_now_err", 2, oe[2], 1'b0);
    ins[0] = 16'h7;   // held high across release: must not count as a pulse
    cyc();
    cyc();
    rst_n = 1'b1;
    do_tick(); chk("rst_t1_data", 3, od[3], 1'b0);
    do_tick(); chk("rst_t2_data", 3, od[3], 1'b0); chk("rst_held_data", 0, od[0], 1'b0);
    ins[0] = '0;

    // N=4 AND back-to-back windows all/none/all.
    pulse(3, 16'hF);
    do_tick();
    do_tick(); chk("b2b_t2_data", 3, od[3], 1'b1);
    pulse(3, 16'hF);
    do_tick(); chk("b2b_t3_data", 3, od[3], 1'b0);
    do_tick(); chk("b2b_t4_data", 3, od[3], 1'b1);

    // N=2 XOR: single cell, result right after the first tick.
    pulse(4, 16'h1);
    do_tick(); chk("n2_one_data", 4, od[4], 1'b1);
    pulse(4, 16'h3);
    do_tick(); chk("n2_two_data", 4, od[4], 1'b0);

    // Random phase: random levels, random SFQ clock, occasional reset.
    for (int c = 0; c < 3000; c++) begin
      clk_sent = 1'($urandom_range(0, 1));
      for (int d = 0; d < NDUT; d++) ins[d] = 16'($urandom);
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      cyc();
    end
    rst_n    = 1'b1;
    clk_sent = 1'b0;
    for (int d = 0; d < NDUT; d++) ins[d] = '0;
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sfq_gate_tree.md
Name: sfq_gate_tree

Overview:
- Parametrised successor of the fixed 3-input SFQ AND2/buffer test top.
- Builds a balanced tree of clocked 2-input SFQ cells over N_INPUTS inputs, with DRO buffers on unpaired branches.
- Models SFQ pulse semantics synchronously: inputs are "sent" strobes, a shared SFQ clock-pulse strobe advances every cell, and the result emerges as an out_data/out_sent pair.
- Serves as the Verilator/UVM DUT for multi-level gate-network checks.

Parameters:
- N_INPUTS, 3: number of data inputs; legal range 2..16.
- GATE_OP, 0: cell function; 0=AND, 1=OR, 2=XOR. Every tree cell uses the same function.
- LEVELS, $clog2(N_INPUTS): derived; tree depth in SFQ ticks. Do not override.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clk_sent  in  1  SFQ clock level; a rising edge is one SFQ tick.
- in_sent  in  N_INPUTS  per-input level; a rising edge on bit i is one data pulse on input i.
- out_data  out  1  tree result for the evaluated window.
- out_sent  out  1  one-cycle strobe marking each evaluation.
- err_setup  out  1  sticky setup-violation flag; present only with the optional feature.

Behaviour:
- Edge detect:
  - Registered copies of clk_sent and in_sent, reset to 0.
  - tick = clk_sent & ~clk_sent_q.
  - pulse[i] = in_sent[i] & ~in_sent_q[i].
- Cell state: each 2-input cell holds arrived_a and arrived_b flags, reset 0.
  - An input pulse sets its flag.
  - A repeated pulse in the same window is idempotent.
- Cell evaluation on tick:
  - Output pulse = OP(arrived_a, arrived_b). The output is delivered to the next level as that level's input pulse in the same cycle, so it lands in the next window.
  - Both flags clear on the tick.
- Simultaneous tick and pulse in the same cycle: the pulse belongs to the next window. Flags clear first, then the pulse sets its flag.
- Unpaired node: when a level has an odd node count, the last node feeds a 1-input DRO buffer. The buffer stores the pulse and re-emits it on the next tick, keeping all paths at exactly LEVELS ticks.
- Latency:
  - Pulses arriving in window k (after tick k-1, up to and including the cycle before tick k) are evaluated by level 1 at tick k.
  - The final cell evaluates at tick k+LEVELS-1.
  - out_sent=1 and out_data=result appear on the clk cycle after that tick.
- Pipelining: consecutive windows overlap, giving one independent result per tick.
- Outputs:
  - out_sent pulses for exactly one cycle after every tick, including ticks whose result is 0.
  - out_data is registered and is 0 whenever out_sent is 0.
- Reset (asynchronous, including mid-operation):
  - All flags, buffers, edge registers, out_data, out_sent and err_setup go to 0.
  - In-flight pulses are discarded.
  - A level still high on clk_sent or in_sent at reset release does not create an edge until it falls and rises again. This is because the edge registers reset to 0 and are then loaded with the current levels.
- N_INPUTS=2 collapses to a single cell with LEVELS=1.

Optional Feature:
- Macro: SFQ_SETUP_CHECK_EN.
- Defined:
  - Any pulse[i] coinciding with tick sets err_setup=1 on the next edge.
  - err_setup holds until reset.
  - Data handling is unchanged: the pulse still goes to the next window.
- Not defined: the err_setup port and its logic are absent.

Decomposition:
- SFQ_PKG gets:
  - gate_op_e enum (GOP_AND, GOP_OR, GOP_XOR).
  - A function returning a cell result from (op, a, b).
  - A localparam max N of 16.
- Sub-module sfq_cell:
  - Handles one clocked node: arrived flags, op, tick clear.
  - A parameter selects 2-input cell or 1-input DRO buffer mode.
  - The top uses a generate loop over levels to instantiate sfq_cell.

Test Plan:
- N=3, AND: pulse in0, in1, in2 before tick1; tick2 -> out_sent=1, out_data=1 one cycle after tick2. Ticks 1 and 3 give out_data=0.
- N=3, AND: pulse in0, in1 only -> out_data=0 after tick2. Then pulse all three in window 3 -> out_data=1 after tick4, with no carry-over from window 1.
- N=5, OR: single pulse on in4 (buffered path) before tick1 -> out_data=1 after tick3 (LEVELS=3), not earlier.
- N=4, XOR: pulses in0, in1, in2 in the same cycle as tick1 -> counted in window 2. After tick2 no result; after tick3 out_data=1. With SFQ_SETUP_CHECK_EN, err_setup=1 from the cycle after tick1.
- N=4, AND: all pulses, tick1, then assert rst_n=0 between ticks -> out_data, out_sent and err_setup read 0 immediately. After release, two ticks with no pulses -> out_data=0.
- Back-to-back windows, N=4, AND: pattern all/none/all over ticks 1-3 -> out_data 1, 0, 1 after ticks 2, 3, 4.
